// File: rtl/lio_mb_rx_fifo_if.sv
// Mailbox-side pop handshake and consumer-side valid/ready stream for lio_mb_rx_fifo.
// The master modport is the FIFO; the slave modport is its surroundings (mailbox plus consumer).
interface lio_mb_rx_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LVL_W      = $clog2(DEPTH + 1)
);
  logic [DATA_WIDTH-1:0] mb_dout;
  logic                  mb_not_empty;
  logic                  mb_rd_en;
  logic                  flush;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [LVL_W-1:0]      level;

  modport master (
    input  mb_dout, mb_not_empty, flush, m_ready,
    output mb_rd_en, m_data, m_valid, level
  );

  modport slave (
    output mb_dout, mb_not_empty, flush, m_ready,
    input  mb_rd_en, m_data, m_valid, level
  );
endinterface

// File: rtl/lio_mb_rx_fifo.sv
// Read-domain FIFO that drains the single-entry mailbox CDC eagerly and presents
// a first-word-fall-through valid/ready stream with occupancy and synchronous flush.
module lio_mb_rx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              arst_clk,
  lio_mb_rx_fifo_if.master  bus
);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]      count;
  logic                  push;
  logic                  pop;

  // Push depends only on registered count, never on m_ready, so a full FIFO
  // waits one cycle after a pop before it accepts the next mailbox word.
  assign push = bus.mb_not_empty & (count != DEPTH_L) & ~bus.flush & ~arst_clk;
  assign pop  = bus.m_valid & bus.m_ready & ~bus.flush;

  assign bus.mb_rd_en = push;
  assign bus.m_valid  = (count != '0);
  assign bus.m_data   = mem[rd_ptr];
  assign bus.level    = count;

  always_ff @(posedge clk or posedge arst_clk) begin
    if (arst_clk) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.mb_dout;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (arst_clk) count <= DEPTH_L);
endmodule
